// File: rtl/cam_capture_stream_if.sv
// Sensor-side and pixel-side signal bundle for cam_capture_stream.
//
// master : the capture engine (samples vsync/href/d, drives the pixel strobe)
// slave  : the environment (drives the sensor pins, consumes the pixel strobe)
//
// Signals
//   vsync, href, d  sensor timing and data bus
//   pix_data        assembled pixel, first sensor byte in the MSBs
//   pix_valid       one-cycle pixel strobe
//   pix_sof         first pixel of a frame (qualified by pix_valid)
//   pix_eol         one-cycle pulse after the last pixel of a line
//   pix_x, pix_y    coordinates of the pixel on pix_data
interface cam_capture_stream_if #(
  parameter int DATA_W          = 8,
  parameter int BYTES_PER_PIXEL = 2,
  parameter int X_W             = 11,
  parameter int Y_W             = 10
);
  logic                              vsync;
  logic                              href;
  logic [DATA_W-1:0]                 d;
  logic [DATA_W*BYTES_PER_PIXEL-1:0] pix_data;
  logic                              pix_valid;
  logic                              pix_sof;
  logic                              pix_eol;
  logic [X_W-1:0]                    pix_x;
  logic [Y_W-1:0]                    pix_y;

  modport master (
    input  vsync, href, d,
    output pix_data, pix_valid, pix_sof, pix_eol, pix_x, pix_y
  );

  modport slave (
    output vsync, href, d,
    input  pix_data, pix_valid, pix_sof, pix_eol, pix_x, pix_y
  );
endinterface

// File: rtl/cam_capture_stream.sv
// Camera pixel-capture engine for OV7670-class parallel sensors.
//
// Tracks frame/line timing from vsync/href, packs BYTES_PER_PIXEL sensor
// bytes into one pixel word (first byte in the MSBs) and emits each pixel
// as a single-cycle strobe with x/y coordinates, start-of-frame and
// end-of-line markers. Everything runs on the rising edge of pclk.
//
// Ports
//   pclk          pixel clock
//   reset         synchronous, active-low
//   enable        capture enable; low forces the engine back to IDLE
//   bus           cam_capture_stream_if.master (sensor pins in, pixel strobe out)
//   frame_done    one-cycle pulse when an emitted frame ends cleanly
//   frame_count   number of clean emitted frames (wraps)
//   err_partial   sticky: href fell in the middle of a pixel
//   err_line_len  sticky: a line's pixel count differs from line 0
module cam_capture_stream #(
  parameter int DATA_W          = 8,
  parameter int BYTES_PER_PIXEL = 2,
  parameter int X_W             = 11,
  parameter int Y_W             = 10,
  parameter int SKIP_FRAMES     = 2
) (
  input  logic                        pclk,
  input  logic                        reset,
  input  logic                        enable,
  cam_capture_stream_if.master        bus,
  output logic                        frame_done,
  output logic [15:0]                 frame_count,
  output logic                        err_partial,
  output logic                        err_line_len
);

  localparam int PIX_W  = DATA_W * BYTES_PER_PIXEL;
  localparam int IDX_W  = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;
  localparam int HOLD_W = (BYTES_PER_PIXEL > 1) ? DATA_W * (BYTES_PER_PIXEL - 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_PIXEL - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FRAME_END,
    WAIT_FRAME_START,
    WAIT_LINE,
    FETCH
  } state_t;

  function automatic logic [X_W-1:0] sat_inc_x(input logic [X_W-1:0] v);
    return (v == {X_W{1'b1}}) ? v : v + X_W'(1);
  endfunction

  function automatic logic [Y_W-1:0] sat_inc_y(input logic [Y_W-1:0] v);
    return (v == {Y_W{1'b1}}) ? v : v + Y_W'(1);
  endfunction

  // Control / frame-tracking state
  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [3:0]        skip_q, skip_d;
  logic              fresh_q, fresh_d;
  logic              got_line_q, got_line_d;
  logic [X_W-1:0]    len0_q, len0_d;
  logic [15:0]       fcnt_q, fcnt_d;
  logic              perr_q, perr_d;
  logic              lerr_q, lerr_d;

  // Byte-assembly stage: earlier bytes of the pixel in progress
  logic [HOLD_W-1:0] hold_p0, hold_d, hold_nx;
  logic [PIX_W-1:0]  shifted;

  // Output register stage
  logic [PIX_W-1:0]  pix_data_p1, pix_data_d;
  logic              vld_p1, vld_d;
  logic              sof_p1, sof_d;
  logic              eol_p1, eol_d;
  logic [X_W-1:0]    pix_x_p1, pix_x_d;
  logic [Y_W-1:0]    pix_y_p1, pix_y_d;
  logic              done_p1, done_d;

  logic              take;
  logic              skipping;

  assign skipping = (skip_q != 4'd0);

  // Pixel word as it would look with the byte on d appended
  generate
    if (BYTES_PER_PIXEL > 1) begin : g_multi
      assign shifted = {hold_p0, bus.d};
      assign hold_nx = shifted[HOLD_W-1:0];
    end else begin : g_single
      assign shifted = bus.d;
      assign hold_nx = '0;
    end
  endgenerate

  always_ff @(posedge pclk) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      skip_q      <= '0;
      fresh_q     <= 1'b0;
      got_line_q  <= 1'b0;
      len0_q      <= '0;
      fcnt_q      <= '0;
      perr_q      <= 1'b0;
      lerr_q      <= 1'b0;
      pix_data_p1 <= '0;
      vld_p1      <= 1'b0;
      sof_p1      <= 1'b0;
      eol_p1      <= 1'b0;
      pix_x_p1    <= '0;
      pix_y_p1    <= '0;
      done_p1     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      x_q         <= x_d;
      y_q         <= y_d;
      skip_q      <= skip_d;
      fresh_q     <= fresh_d;
      got_line_q  <= got_line_d;
      len0_q      <= len0_d;
      fcnt_q      <= fcnt_d;
      perr_q      <= perr_d;
      lerr_q      <= lerr_d;
      pix_data_p1 <= pix_data_d;
      vld_p1      <= vld_d;
      sof_p1      <= sof_d;
      eol_p1      <= eol_d;
      pix_x_p1    <= pix_x_d;
      pix_y_p1    <= pix_y_d;
      done_p1     <= done_d;
    end
  end

  // Assembly register carries data only, so it is left out of reset.
  always_ff @(posedge pclk) begin
    hold_p0 <= hold_d;
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    hold_d     = hold_p0;
    x_d        = x_q;
    y_d        = y_q;
    skip_d     = skip_q;
    fresh_d    = fresh_q;
    got_line_d = got_line_q;
    len0_d     = len0_q;
    fcnt_d     = fcnt_q;
    perr_d     = perr_q;
    lerr_d     = lerr_q;
    pix_data_d = pix_data_p1;
    vld_d      = 1'b0;
    sof_d      = 1'b0;
    eol_d      = 1'b0;
    pix_x_d    = pix_x_p1;
    pix_y_d    = pix_y_p1;
    done_d     = 1'b0;
    take       = 1'b0;

    if (!enable) begin
      state_d = IDLE;
      idx_d   = '0;
      x_d     = '0;
      y_d     = '0;
      skip_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = WAIT_FRAME_END;
          skip_d  = 4'(SKIP_FRAMES);
        end

        // Whatever frame is running when capture starts is thrown away.
        WAIT_FRAME_END: begin
          if (bus.vsync) state_d = WAIT_FRAME_START;
        end

        WAIT_FRAME_START: begin
          if (!bus.vsync) begin
            state_d    = WAIT_LINE;
            idx_d      = '0;
            x_d        = '0;
            y_d        = '0;
            fresh_d    = 1'b1;
            got_line_d = 1'b0;
          end
        end

        WAIT_LINE: begin
          if (bus.vsync) begin
            state_d = WAIT_FRAME_START;
            if (skipping) begin
              skip_d = skip_q - 4'd1;
            end else if (got_line_q) begin
              done_d = 1'b1;
              fcnt_d = fcnt_q + 16'd1;
            end
          end else if (bus.href) begin
            // The byte on d at this edge is already byte 0 of the line.
            state_d = FETCH;
            take    = 1'b1;
          end
        end

        FETCH: begin
          if (bus.vsync) begin
            // Frame cut short: drop it without counting it.
            state_d = WAIT_FRAME_START;
            idx_d   = '0;
            x_d     = '0;
          end else if (bus.href) begin
            take = 1'b1;
          end else begin
            state_d    = WAIT_LINE;
            idx_d      = '0;
            x_d        = '0;
            y_d        = sat_inc_y(y_q);
            got_line_d = 1'b1;
            if (!skipping) begin
              eol_d = 1'b1;
              if (idx_q != '0) perr_d = 1'b1;
              // x_q holds the number of pixels emitted on this line.
              if (y_q == '0) begin
                len0_d = x_q;
              end else if (x_q != len0_q) begin
                lerr_d = 1'b1;
              end
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end

    if (take) begin
      hold_d = hold_nx;
      if (idx_q == LAST_IDX) begin
        idx_d   = '0;
        x_d     = sat_inc_x(x_q);
        fresh_d = 1'b0;
        if (!skipping) begin
          vld_d      = 1'b1;
          sof_d      = fresh_q;
          pix_data_d = shifted;
          pix_x_d    = x_q;
          pix_y_d    = y_q;
        end
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  assign bus.pix_data  = pix_data_p1;
  assign bus.pix_valid = vld_p1;
  assign bus.pix_sof   = sof_p1;
  assign bus.pix_eol   = eol_p1;
  assign bus.pix_x     = pix_x_p1;
  assign bus.pix_y     = pix_y_p1;
  assign frame_done    = done_p1;
  assign frame_count   = fcnt_q;
  assign err_partial   = perr_q;
  assign err_line_len  = lerr_q;

  a_eol_not_with_valid: assert property (@(posedge pclk) disable iff (!reset)
    !(vld_p1 && eol_p1));

  a_sof_at_origin: assert property (@(posedge pclk) disable iff (!reset)
    sof_p1 |-> (vld_p1 && pix_x_p1 == '0 && pix_y_p1 == '0));

endmodule

// File: tb/tb_cam_capture_stream.sv
// Directed self-checking bench for cam_capture_stream.
// Two instances share the sensor stimulus: dut0 (SKIP_FRAMES=0) and
// dut2 (SKIP_FRAMES=2), each with its own enable.
module tb_cam_capture_stream;

  logic       pclk = 1'b0;
  logic       reset;
  logic       enable0, enable2;
  logic       vsync, href;
  logic [7:0] d;

  logic        fd0, ep0, el0, fd2, ep2, el2;
  logic [15:0] fc0, fc2;

  int n_checks = 0;
  int n_errors = 0;

  // Monitor accumulators (written only by the monitor process)
  int pv0_cnt = 0, eol0_cnt = 0, done0_cnt = 0, sof0_cnt = 0, ovl0_cnt = 0;
  int pv2_cnt = 0, eol2_cnt = 0, done2_cnt = 0;
  logic [15:0] sof0_data = '0, last0_data = '0;
  logic [10:0] sof0_x = '0, last0_x = '0;
  logic [9:0]  sof0_y = '0, last0_y = '0;

  logic [15:0] pv_pat, eol_pat;
  int b_pv, b_eol, b_done, b_sof;

  cam_capture_stream_if #(.DATA_W(8), .BYTES_PER_PIXEL(2), .X_W(11), .Y_W(10)) if0 ();
  cam_capture_stream_if #(.DATA_W(8), .BYTES_PER_PIXEL(2), .X_W(11), .Y_W(10)) if2 ();

  assign if0.vsync = vsync;
  assign if0.href  = href;
  assign if0.d     = d;
  assign if2.vsync = vsync;
  assign if2.href  = href;
  assign if2.d     = d;

  cam_capture_stream #(.DATA_W(8), .BYTES_PER_PIXEL(2), .X_W(11), .Y_W(10), .SKIP_FRAMES(0)) dut0 (
    .pclk(pclk), .reset(reset), .enable(enable0), .bus(if0),
    .frame_done(fd0), .frame_count(fc0), .err_partial(ep0), .err_line_len(el0)
  );

  cam_capture_stream #(.DATA_W(8), .BYTES_PER_PIXEL(2), .X_W(11), .Y_W(10), .SKIP_FRAMES(2)) dut2 (
    .pclk(pclk), .reset(reset), .enable(enable2), .bus(if2),
    .frame_done(fd2), .frame_count(fc2), .err_partial(ep2), .err_line_len(el2)
  );

  always #5 pclk = ~pclk;

  always @(negedge pclk) begin
    if (if0.pix_valid) begin
      pv0_cnt++;
      last0_data = if0.pix_data;
      last0_x    = if0.pix_x;
      last0_y    = if0.pix_y;
      if (if0.pix_sof) begin
        sof0_cnt++;
        sof0_data = if0.pix_data;
        sof0_x    = if0.pix_x;
        sof0_y    = if0.pix_y;
      end
    end
    if (if0.pix_eol) eol0_cnt++;
    if (if0.pix_valid && if0.pix_eol) ovl0_cnt++;
    if (fd0) done0_cnt++;
    if (if2.pix_valid) pv2_cnt++;
    if (if2.pix_eol) eol2_cnt++;
    if (fd2) done2_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives nbytes bytes first, first+1, ... with href high, then 4 idle
  // edges. Samples dut0 pix_valid/pix_eol 1 time unit after each edge.
  task automatic send_line(input int nbytes, input logic [7:0] first);
    pv_pat  = '0;
    eol_pat = '0;
    for (int i = 0; i < nbytes + 4; i++) begin
      @(posedge pclk); #1;
      pv_pat  = {pv_pat[14:0], if0.pix_valid};
      eol_pat = {eol_pat[14:0], if0.pix_eol};
      if (i < nbytes) begin
        href = 1'b1;
        d    = first + 8'(i);
      end else begin
        href = 1'b0;
        d    = 8'h00;
      end
    end
  endtask

  task automatic vsync_pulse();
    @(posedge pclk); #1;
    vsync = 1'b1;
    href  = 1'b0;
    repeat (3) @(posedge pclk);
    #1 vsync = 1'b0;
    repeat (3) @(posedge pclk);
  endtask

  task automatic snap0();
    b_pv   = pv0_cnt;
    b_eol  = eol0_cnt;
    b_done = done0_cnt;
    b_sof  = sof0_cnt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset   = 1'b0;
    enable0 = 1'b0;
    enable2 = 1'b0;
    vsync   = 1'b0;
    href    = 1'b0;
    d       = 8'h00;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check("rst_valid", 32'(if0.pix_valid), 32'h0);
    check("rst_data",  32'(if0.pix_data), 32'h0);
    check("rst_xy",    32'({if0.pix_x, if0.pix_y}), 32'h0);
    check("rst_marks", 32'({if0.pix_sof, if0.pix_eol, fd0}), 32'h0);
    check("rst_fcnt",  32'(fc0), 32'h0);
    check("rst_errs",  32'({ep0, el0, ep2, el2}), 32'h0);
    #1 reset = 1'b1;

    // ---- Basic frame: 3 lines x 8 bytes, d = 0x01..0x18 ----
    enable0 = 1'b1;
    repeat (2) @(posedge pclk);
    vsync_pulse();
    snap0();
    send_line(8, 8'h01);
    // pixels at samples 2,4,6,8 (one cycle after each odd byte), eol at sample 9
    check("line0_valid_pattern", 32'(pv_pat), 32'h2A8);
    check("line0_eol_pattern",   32'(eol_pat), 32'h004);
    send_line(8, 8'h09);
    send_line(8, 8'h11);
    vsync_pulse();
    check("f1_pixels",   32'(pv0_cnt - b_pv), 32'd12);
    check("f1_sof_cnt",  32'(sof0_cnt - b_sof), 32'd1);
    check("f1_sof_data", 32'(sof0_data), 32'h0102);
    check("f1_sof_xy",   32'({sof0_x, sof0_y}), 32'h0);
    check("f1_last_data", 32'(last0_data), 32'h1718);
    check("f1_last_x",   32'(last0_x), 32'd3);
    check("f1_last_y",   32'(last0_y), 32'd2);
    check("f1_eol_cnt",  32'(eol0_cnt - b_eol), 32'd3);
    check("f1_done_cnt", 32'(done0_cnt - b_done), 32'd1);
    check("f1_fcount",   32'(fc0), 32'd1);
    check("f1_errs",     32'({ep0, el0}), 32'h0);

    // ---- Partial pixel: 7-byte line ----
    snap0();
    send_line(7, 8'h21);
    check("partial_pixels", 32'(pv0_cnt - b_pv), 32'd3);
    check("partial_err",    32'(ep0), 32'h1);
    check("partial_eol",    32'(eol0_cnt - b_eol), 32'd1);
    check("partial_lenerr", 32'(el0), 32'h0);
    vsync_pulse();
    check("partial_fcount", 32'(fc0), 32'd2);

    // ---- Line length mismatch: 8, 8, 6 bytes ----
    snap0();
    send_line(8, 8'h01);
    send_line(8, 8'h01);
    check("len_err_before", 32'(el0), 32'h0);
    send_line(6, 8'h01);
    check("len_err_after",  32'(el0), 32'h1);
    check("len_pixels",     32'(pv0_cnt - b_pv), 32'd11);
    vsync_pulse();
    check("len_fcount",     32'(fc0), 32'd3);
    check("len_partial_sticky", 32'(ep0), 32'h1);

    // ---- Abort: vsync rises mid-line in line 1 ----
    snap0();
    send_line(8, 8'h31);
    for (int i = 0; i < 4; i++) begin
      @(posedge pclk); #1;
      href = 1'b1;
      d    = 8'h39 + 8'(i);
    end
    @(posedge pclk); #1;
    vsync = 1'b1;
    href  = 1'b0;
    repeat (3) @(posedge pclk);
    #1 vsync = 1'b0;
    repeat (3) @(posedge pclk);
    check("abort_last_data", 32'(last0_data), 32'h3B3C);
    check("abort_last_y",    32'(last0_y), 32'd1);
    check("abort_no_done",   32'(done0_cnt - b_done), 32'd0);
    check("abort_fcount",    32'(fc0), 32'd3);
    send_line(8, 8'h41);
    check("restart_sof_cnt",  32'(sof0_cnt - b_sof), 32'd2);
    check("restart_sof_data", 32'(sof0_data), 32'h4142);
    check("restart_y",        32'(last0_y), 32'd0);
    check("restart_pixels",   32'(pv0_cnt - b_pv), 32'd10);
    vsync_pulse();
    check("restart_fcount",   32'(fc0), 32'd4);

    // ---- Reset pulse mid-FETCH ----
    @(posedge pclk); #1;
    href = 1'b1;
    d    = 8'h51;
    @(posedge pclk); #1;
    d = 8'h52;
    @(posedge pclk); #1;
    d     = 8'h53;
    reset = 1'b0;
    @(posedge pclk); #1;
    reset = 1'b1;
    d     = 8'h54;
    @(negedge pclk);
    check("mid_rst_valid", 32'(if0.pix_valid), 32'h0);
    check("mid_rst_data",  32'(if0.pix_data), 32'h0);
    check("mid_rst_xy",    32'({if0.pix_x, if0.pix_y}), 32'h0);
    check("mid_rst_fcnt",  32'(fc0), 32'h0);
    check("mid_rst_errs",  32'({ep0, el0}), 32'h0);
    snap0();
    send_line(8, 8'h55);
    check("post_rst_no_pix", 32'(pv0_cnt - b_pv), 32'd0);
    check("post_rst_no_eol", 32'(eol0_cnt - b_eol), 32'd0);
    vsync_pulse();
    send_line(8, 8'h61);
    check("post_rst_pixels", 32'(pv0_cnt - b_pv), 32'd4);
    check("post_rst_sof",    32'(sof0_data), 32'h6162);

    // ---- Frame skipping on dut2 (SKIP_FRAMES=2) ----
    b_pv   = pv2_cnt;
    b_eol  = eol2_cnt;
    b_done = done2_cnt;
    @(posedge pclk); #1 enable2 = 1'b1;
    repeat (2) @(posedge pclk);
    vsync_pulse();
    send_line(8, 8'h01);
    send_line(8, 8'h09);
    check("skip_f1_pixels", 32'(pv2_cnt - b_pv), 32'd0);
    vsync_pulse();
    send_line(8, 8'h01);
    send_line(8, 8'h09);
    check("skip_f2_pixels", 32'(pv2_cnt - b_pv), 32'd0);
    check("skip_f2_eol",    32'(eol2_cnt - b_eol), 32'd0);
    check("skip_f2_done",   32'(done2_cnt - b_done), 32'd0);
    vsync_pulse();
    send_line(8, 8'h01);
    send_line(8, 8'h09);
    check("skip_f3_pixels", 32'(pv2_cnt - b_pv), 32'd8);
    check("skip_f3_eol",    32'(eol2_cnt - b_eol), 32'd2);
    vsync_pulse();
    check("skip_done",   32'(done2_cnt - b_done), 32'd1);
    check("skip_fcount", 32'(fc2), 32'd1);

    check("eol_valid_overlap", 32'(ovl0_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cam_capture_stream.md
# cam_capture_stream

Parametrised camera pixel-capture engine for OV7670-class parallel sensors, running entirely in the `pclk` domain. It tracks frame and line timing from `vsync`/`href` and assembles `BYTES_PER_PIXEL` sensor bytes into one pixel word. Each pixel is emitted as a single-cycle strobe carrying its x/y coordinates and start-of-frame / end-of-line markers. It sits between the sensor pins and the pixel FIFO/framebuffer writer, and is held idle until the register-setup sequencer asserts `enable`.

## Interface
- `DATA_W`, 8, sensor data bus width.
- `BYTES_PER_PIXEL`, 2, bytes per pixel (1..4); first byte received lands in the MSBs.
- `X_W`, 11, width of the column counter.
- `Y_W`, 10, width of the row counter.
- `SKIP_FRAMES`, 2, whole frames discarded after `enable` rises (0..15).

Ports:
- `pclk`  in  1  pixel clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-low.
- `enable`  in  1  capture enable (sensor setup complete).
- `vsync`  in  1  vertical sync, active high.
- `href`  in  1  horizontal reference, high during active bytes.
- `d`  in  DATA_W  sensor data.
- `pix_data`  out  DATA_W*BYTES_PER_PIXEL  assembled pixel.
- `pix_valid`  out  1  one-cycle strobe, `pix_data`/`pix_x`/`pix_y` valid.
- `pix_sof`  out  1  with `pix_valid`: first pixel of frame (x=0, y=0).
- `pix_eol`  out  1  one-cycle pulse on the cycle after `href` falls in an emitted line.
- `pix_x`  out  X_W  column of current pixel.
- `pix_y`  out  Y_W  row of current pixel.
- `frame_done`  out  1  one-cycle pulse when an emitted frame ends cleanly.
- `frame_count`  out  16  count of clean emitted frames; wraps at 0xFFFF -> 0.
- `err_partial`  out  1  sticky: `href` fell mid-pixel.
- `err_line_len`  out  1  sticky: line length differs from the frame's first line.

## Operation
- States: IDLE, WAIT_FRAME_END, WAIT_FRAME_START, WAIT_LINE, FETCH.
- Reset (`reset`=0), or `enable`=0 in any state: go to IDLE next cycle and clear byte index, x, y and the skip counter.
  - Reset additionally clears `frame_count` and both error flags.
  - All outputs are 0 after reset.
- IDLE: when `enable`=1 -> WAIT_FRAME_END; load the skip counter with SKIP_FRAMES.
- WAIT_FRAME_END: `vsync`=1 -> WAIT_FRAME_START. This discards the frame in progress when capture starts.
- WAIT_FRAME_START: `vsync`=0 -> WAIT_LINE; y=0, frame marked "fresh" (next pixel gets `pix_sof`).
- WAIT_LINE:
  - `href`=1 -> FETCH. The byte sampled on this same edge is byte 0 of pixel 0; no byte is lost on the transition.
  - `vsync`=1 -> end of frame:
    - If the skip counter is >0, decrement it; `frame_done` is not pulsed.
    - Otherwise pulse `frame_done` and increment `frame_count`, provided at least one line was captured.
    - Next state is WAIT_FRAME_START.
- FETCH:
  - Each edge with `href`=1 shifts `d` into the assembly register and increments the byte index.
  - On byte index BYTES_PER_PIXEL-1: emit the pixel, reset the index, and increment x after emission.
  - `href`=0: if the byte index is ≠0, drop the partial pixel and set `err_partial`. Then pulse `pix_eol`, set x=0, increment y, and go to WAIT_LINE.
  - `vsync`=1 while in FETCH: abort the frame. No `frame_done`, no `frame_count` change, discard any partial pixel; go to WAIT_FRAME_START.
- Frames still being skipped advance all counters but suppress `pix_valid`, `pix_sof` and `pix_eol`.
- Line length: the pixel count of line 0 is latched. Any later line with a different count sets `err_line_len`, checked at `href` fall.
- x saturates at 2^X_W−1 and y at 2^Y_W−1; there is no wrap and no extra error.
- Error flags clear only on reset.

## Timing
- All outputs are registered.
- `pix_valid` rises on the cycle after the edge that samples the final byte of a pixel, so latency from last byte = 1 cycle.
- With BYTES_PER_PIXEL=2 and continuous `href`, `pix_valid` pulses every 2nd cycle; with BYTES_PER_PIXEL=1 it pulses every cycle.
- `pix_x`/`pix_y` hold their values between strobes.
- `pix_eol` follows the last `pix_valid` of the line by at least 1 cycle and never coincides with `pix_valid`.
- `frame_done` fires 1 cycle after the `vsync` rising edge is sampled in WAIT_LINE.
- If `enable` drops in the same cycle as a completing byte, the pixel is not emitted.

## Test plan
- SKIP_FRAMES=0, BPP=2; frame of 3 lines × 8 bytes, d=0x01..0x18 -> 12 `pix_valid`:
  - first `pix_data`=0x0102 with `pix_sof`=1, x=0, y=0;
  - last `pix_data`=0x1718 with x=3, y=2;
  - 3 `pix_eol` pulses, 1 `frame_done`, `frame_count`=1.
- SKIP_FRAMES=2; 4 identical frames after `enable` -> (startup frame discarded) no output for frames 1–2, pixels only from frame 3, `frame_count`=1.
- Line of 7 bytes with BPP=2 -> 3 pixels emitted, `err_partial`=1, `pix_eol` still pulses.
- Lines of 8, 8, 6 bytes -> `err_line_len` set after the third line; 11 pixels total.
- `vsync` raised mid-line in line 1 -> no `frame_done`, `frame_count` unchanged; the next clean frame restarts at y=0 with `pix_sof`.
- `reset`=0 for 1 cycle mid-FETCH -> all outputs 0 and errors cleared next cycle; no pixels emitted until after a full `vsync` high→low sequence.
